// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting each complete neighbourhood (row-major, p0 top-left) one cycle after the pixel lands.
module sobel_window_gen #(
  parameter int N  = 450,
  parameter int M  = 600,
  parameter int RW = 9,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          data_valid,
  input  logic          frame_start,
  input  logic [7:0]    Din,
  output logic          window_valid,
  output logic [71:0]   win,
  output logic [RW-1:0] cen_row,
  output logic [CW-1:0] cen_col,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE} state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(M - 1);

  logic [7:0]    lb0_q [M];
  logic [7:0]    lb1_q [M];

  state_t        state_q, state_d, state_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic [CW-1:0] col_q, col_d, col_eff;
  logic [71:0]   win_q;
  logic [RW-1:0] cen_row_q;
  logic [CW-1:0] cen_col_q;
  logic          win_valid_q, done_q;

  logic [7:0]    lb0_rd, lb1_rd;
  logic          col_last, last_px, emit;

  // frame_start overrides position and state before the accept decision,
  // so a pixel arriving with it is handled exactly like pixel (0,0) from IDLE.
  always_comb begin
    row_eff   = frame_start ? '0   : row_q;
    col_eff   = frame_start ? '0   : col_q;
    state_eff = frame_start ? IDLE : state_q;

    lb0_rd   = lb0_q[col_eff];
    lb1_rd   = lb1_q[col_eff];
    col_last = (col_eff == COL_LAST);
    last_px  = col_last && (row_eff == ROW_LAST);
    emit     = data_valid && (state_eff == ACTIVE) && (col_eff >= CW'(2));

    row_d   = row_eff;
    col_d   = col_eff;
    state_d = state_eff;

    if (data_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
      end

      unique case (state_eff)
        IDLE:    state_d = FILL;
        FILL:    if (col_last && (row_eff == RW'(1))) state_d = ACTIVE;
        ACTIVE:  if (last_px) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      cen_row_q   <= '0;
      cen_col_q   <= '0;
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= emit;
      done_q      <= data_valid && last_px;
      if (data_valid) begin
        win_q     <= {win_q[63:48], lb1_rd, win_q[39:24], lb0_rd, win_q[15:0], Din};
        cen_row_q <= row_eff - RW'(1);
        cen_col_q <= col_eff - CW'(1);
      end
    end
  end

  // Line buffers are plain RAM; stale contents never reach a valid window.
  always_ff @(posedge clk) begin
    if (data_valid) begin
      lb1_q[col_eff] <= lb0_rd;
      lb0_q[col_eff] <= Din;
    end
  end

  assign window_valid = win_valid_q;
  assign win          = win_q;
  assign cen_row      = cen_row_q;
  assign cen_col      = cen_col_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x5 image: a frame-memory model
// predicts every window, the monitor compares each strobe against the queue.
module tb_sobel_window_gen;

  localparam int N  = 4;
  localparam int M  = 5;
  localparam int RW = 3;
  localparam int CW = 3;

  localparam logic [79:0] F0_FIRST = {1'b0, 72'h00_01_02_05_06_07_0A_0B_0C, 3'd1, 3'd1, 1'b0};
  localparam logic [79:0] F0_LAST  = {1'b0, 72'h07_08_09_0C_0D_0E_11_12_13, 3'd2, 3'd3, 1'b1};
  localparam logic [79:0] F40_FIRST = {1'b0, 72'h40_41_42_45_46_47_4A_4B_4C, 3'd1, 3'd1, 1'b0};
  localparam logic [79:0] F20_FIRST = {1'b0, 72'h20_21_22_25_26_27_2A_2B_2C, 3'd1, 3'd1, 1'b0};
  localparam logic [79:0] F60_FIRST = {1'b0, 72'h60_61_62_65_66_67_6A_6B_6C, 3'd1, 3'd1, 1'b0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [7:0]    Din = '0;
  logic          window_valid;
  logic [71:0]   win;
  logic [RW-1:0] cen_row;
  logic [CW-1:0] cen_col;
  logic          done;

  sobel_window_gen #(.N(N), .M(M), .RW(RW), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_valid   (data_valid),
    .frame_start  (frame_start),
    .Din          (Din),
    .window_valid (window_valid),
    .win          (win),
    .cen_row      (cen_row),
    .cen_col      (cen_col),
    .done         (done)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;

  logic [79:0] sb_q [$];
  logic [79:0] obs_q [$];
  logic [79:0] ref_q [$];
  logic [7:0]  pix [N][M];
  int          m_row = 0;
  int          m_col = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [79:0] out_vec();
    return {window_valid, win, cen_row, cen_col, done};
  endfunction

  function automatic logic [79:0] last_obs();
    return (obs_q.size() > 0) ? obs_q[$] : '0;
  endfunction

  function automatic logic [79:0] first_obs(input int idx);
    return (obs_q.size() > idx) ? obs_q[idx] : '0;
  endfunction

  task automatic send(input logic [7:0] d, input logic fs);
    @(negedge clk);
    data_valid  = 1'b1;
    frame_start = fs;
    Din         = d;
    if (fs) begin
      m_row = 0;
      m_col = 0;
    end
    pix[m_row][m_col] = d;
    if (m_row >= 2 && m_col >= 2)
      sb_q.push_back({1'b0,
                      pix[m_row-2][m_col-2], pix[m_row-2][m_col-1], pix[m_row-2][m_col],
                      pix[m_row-1][m_col-2], pix[m_row-1][m_col-1], pix[m_row-1][m_col],
                      pix[m_row][m_col-2],   pix[m_row][m_col-1],   pix[m_row][m_col],
                      3'(m_row - 1), 3'(m_col - 1), (m_row == N-1 && m_col == M-1)});
    if (m_col == M-1) begin
      m_col = 0;
      m_row = (m_row == N-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_valid  = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic frame(input int off, input bit gaps);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < M; c++) begin
        send(8'(off + r*M + c), 1'b0);
        if (gaps) idle($urandom_range(0, 3));
      end
  endtask

  always @(negedge clk) begin
    if (window_valid) begin
      strobe_cnt++;
      if (done) done_cnt++;
      obs_q.push_back({1'b0, win, cen_row, cen_col, done});
      if (sb_q.size() == 0) check("unexpected_wv", {79'b0, window_valid}, 80'b0);
      else check("sb_window", {1'b0, win, cen_row, cen_col, done}, sb_q.pop_front());
    end else if (done) begin
      check("done_without_wv", {79'b0, done}, 80'b0);
    end
  end

  initial begin
    int s0, d0;

    repeat (3) @(negedge clk);
    check("reset_outputs", out_vec(), '0);
    rst_n = 1'b1;
    idle(3);
    check("idle_outputs", out_vec(), '0);

    // reset while a window is being presented
    for (int k = 0; k < 13; k++) send(8'(k), 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", out_vec(), '0);
    idle(2);
    rst_n = 1'b1;
    m_row = 0;
    m_col = 0;
    sb_q.delete();
    idle(2);
    check("post_reset_idle", out_vec(), '0);

    s0 = strobe_cnt; d0 = done_cnt; obs_q.delete();
    frame(0, 1'b0);
    idle(2);
    check("f0_count", 80'(strobe_cnt - s0), 80'd6);
    check("f0_first", first_obs(0), F0_FIRST);
    check("f0_last", last_obs(), F0_LAST);
    check("f0_done", 80'(done_cnt - d0), 80'd1);
    ref_q = obs_q;

    s0 = strobe_cnt; d0 = done_cnt; obs_q.delete();
    frame(0, 1'b1);
    idle(2);
    check("gap_count", 80'(strobe_cnt - s0), 80'd6);
    check("gap_done", 80'(done_cnt - d0), 80'd1);
    for (int i = 0; i < ref_q.size(); i++) check("gap_seq", first_obs(i), ref_q[i]);

    s0 = strobe_cnt; d0 = done_cnt; obs_q.delete();
    frame(0, 1'b0);
    frame(8'h40, 1'b0);
    idle(2);
    check("b2b_count", 80'(strobe_cnt - s0), 80'd12);
    check("b2b_f1_last", first_obs(5), F0_LAST);
    check("b2b_f2_first", first_obs(6), F40_FIRST);
    check("b2b_done", 80'(done_cnt - d0), 80'd2);

    s0 = strobe_cnt; d0 = done_cnt; obs_q.delete();
    for (int k = 0; k < 11; k++) send(8'(8'h80 + k), 1'b0);
    send(8'h20, 1'b1);
    for (int k = 1; k < N*M; k++) send(8'(8'h20 + k), 1'b0);
    idle(2);
    check("abort_count", 80'(strobe_cnt - s0), 80'd6);
    check("abort_first", first_obs(0), F20_FIRST);
    check("abort_done", 80'(done_cnt - d0), 80'd1);

    s0 = strobe_cnt; d0 = done_cnt; obs_q.delete();
    for (int k = 0; k < 9; k++) send(8'(8'h90 + k), 1'b0);
    @(negedge clk);
    data_valid  = 1'b0;
    frame_start = 1'b1;
    m_row = 0;
    m_col = 0;
    idle(1);
    check("fs_idle_outputs", {79'b0, window_valid | done}, '0);
    frame(8'h60, 1'b0);
    idle(2);
    check("fsidle_count", 80'(strobe_cnt - s0), 80'd6);
    check("fsidle_first", first_obs(0), F60_FIRST);
    check("fsidle_done", 80'(done_cnt - d0), 80'd1);

    check("sb_drained", 80'(sb_q.size()), 80'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
